// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with tick-based debounce; accepted keys are
// shifted into a 16-bit hex entry register and flagged with a one-cycle strobe.
module keypad_entry #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  col_i,
    output logic [3:0]  row_o,
    input  logic        clr_i,
    output logic [15:0] reg_16_o,
    output logic [3:0]  key_o,
    output logic        key_valid_o
);

    // state     | meaning
    // SCAN      | rotating rows, sampling one row per tick
    // DEB_PRESS | row held, counting ticks with the latched single-low pattern
    // HELD      | key accepted, waiting for all columns to go high
    // DEB_REL   | counting ticks with all columns high before rescanning
    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    state_t             r_state;
    logic [3:0]         r_col_s1;
    logic [3:0]         r_col_s2;
    logic [DIV_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_pat;
    logic [1:0]         r_row_idx;

    logic               w_tick;
    logic               w_one_low;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_accept;
    logic [3:0]         w_code;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
            r_div    <= '0;
        end else begin
            r_col_s1 <= col_i;
            r_col_s2 <= r_col_s1;
            r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    assign w_tick    = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_one_low = 1'b0;
        case (r_col_s2)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_one_low = 1'b1;
            default:                            w_one_low = 1'b0;
        endcase
    end

    // The accepted pattern always equals colS, so the code is decoded from it directly.
    always_comb begin
        logic [1:0] col;
        col = 2'd0;
        case (r_col_s2)
            4'b1101: col = 2'd1;
            4'b1011: col = 2'd2;
            4'b0111: col = 2'd3;
            default: col = 2'd0;
        endcase
        w_code = 4'h0;
        case ({r_row_idx, col})
            4'h0: w_code = 4'h1;  4'h1: w_code = 4'h2;  4'h2: w_code = 4'h3;  4'h3: w_code = 4'hA;
            4'h4: w_code = 4'h4;  4'h5: w_code = 4'h5;  4'h6: w_code = 4'h6;  4'h7: w_code = 4'hB;
            4'h8: w_code = 4'h7;  4'h9: w_code = 4'h8;  4'hA: w_code = 4'h9;  4'hB: w_code = 4'hC;
            4'hC: w_code = 4'hE;  4'hD: w_code = 4'h0;  4'hE: w_code = 4'hF;  default: w_code = 4'hD;
        endcase
    end

    assign w_accept = w_tick &&
        (((r_state == SCAN) && w_one_low && (DEBOUNCE_CNT == 1)) ||
         ((r_state == DEB_PRESS) && (r_col_s2 == r_pat) &&
          (w_cnt_inc == CNT_W'(DEBOUNCE_CNT))));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= SCAN;
            r_cnt       <= '0;
            r_pat       <= 4'hF;
            r_row_idx   <= 2'd0;
            row_o       <= 4'b1110;
            reg_16_o    <= '0;
            key_o       <= '0;
            key_valid_o <= 1'b0;
        end else begin
            key_valid_o <= w_accept;
            if (w_accept)
                key_o <= w_code;
            if (clr_i)
                reg_16_o <= '0;
            else if (w_accept)
                reg_16_o <= {reg_16_o[11:0], w_code};

            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_one_low) begin
                            r_pat   <= r_col_s2;
                            r_cnt   <= CNT_W'(1);
                            r_state <= (DEBOUNCE_CNT == 1) ? HELD : DEB_PRESS;
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            row_o     <= {row_o[2:0], row_o[3]};
                        end
                    end
                    DEB_PRESS: begin
                        if (r_col_s2 == r_pat) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_W'(DEBOUNCE_CNT))
                                r_state <= HELD;
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            row_o     <= {row_o[2:0], row_o[3]};
                            r_state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (r_col_s2 == 4'hF) begin
                            r_cnt <= CNT_W'(1);
                            if (DEBOUNCE_CNT == 1) begin
                                r_row_idx <= r_row_idx + 2'd1;
                                row_o     <= {row_o[2:0], row_o[3]};
                                r_state   <= SCAN;
                            end else begin
                                r_state <= DEB_REL;
                            end
                        end
                    end
                    DEB_REL: begin
                        if (r_col_s2 == 4'hF) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                                r_row_idx <= r_row_idx + 2'd1;
                                row_o     <= {row_o[2:0], row_o[3]};
                                r_state   <= SCAN;
                            end
                        end else begin
                            r_state <= HELD;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad matrix model drives col_i from row_o, and a
// scoreboard of expected (key, value) pairs is checked on every strobe.
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [3:0]  col_i;
    logic [3:0]  row_o;
    logic        clr_i = 1'b0;
    logic [15:0] reg_16_o;
    logic [3:0]  key_o;
    logic        key_valid_o;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .col_i       (col_i),
        .row_o       (row_o),
        .clr_i       (clr_i),
        .reg_16_o    (reg_16_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  key;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          n_strobe = 0;
    int          n_pushed = 0;
    logic [15:0] exp_reg = 16'h0;
    logic [15:0] pressed = 16'h0;
    logic        prev_valid = 1'b0;
    logic [3:0]  pos_code [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                   4'h4, 4'h5, 4'h6, 4'hB,
                                   4'h7, 4'h8, 4'h9, 4'hC,
                                   4'hE, 4'h0, 4'hF, 4'hD};

    // Matrix model: a closed switch pulls its column low while its row is driven low.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_o[r])
                    col_i[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && key_valid_o) begin
            exp_t e;
            n_strobe++;
            chk("strobe_gap", {15'd0, prev_valid}, 16'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {12'd0, key_o}, 16'hFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_key", {12'd0, key_o}, {12'd0, e.key});
                chk("sb_reg", reg_16_o, e.val);
            end
        end
        prev_valid = key_valid_o;
    end

    function automatic int key_pos(input logic [3:0] code);
        for (int i = 0; i < 16; i++)
            if (pos_code[i] == code) return i;
        return 0;
    endfunction

    task automatic expect_key(input logic [3:0] code, input logic [15:0] val);
        exp_t e;
        e.key = code;
        e.val = val;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    task automatic wait_row(input logic [3:0] r);
        int n = 0;
        while (row_o !== r && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (row_o !== r) chk("row_wait", {12'd0, row_o}, {12'd0, r});
    endtask

    task automatic press_key(input logic [3:0] code, input int hold_ticks);
        exp_reg = {exp_reg[11:0], code};
        expect_key(code, exp_reg);
        pressed[key_pos(code)] = 1'b1;
        repeat (hold_ticks * SD) @(posedge clk_i);
        @(negedge clk_i);
        pressed = 16'h0;
        repeat (8 * SD) @(negedge clk_i);
    endtask

    initial begin
        logic [3:0] exp_rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [3:0] last_row;
        int         changes;

        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        chk("rst_row", {12'd0, row_o}, 16'h000E);
        chk("rst_reg", reg_16_o, 16'h0);
        chk("rst_key", {12'd0, key_o}, 16'h0);
        chk("rst_valid", {15'd0, key_valid_o}, 16'h0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rotate", {12'd0, row_o}, {12'd0, exp_rows[i]});
            repeat (SD) @(negedge clk_i);
        end

        press_key(4'h6, 40);
        chk("single_reg", reg_16_o, 16'h0006);
        chk("single_cnt", 16'(n_strobe), 16'd1);

        press_key(4'h1, 10);
        press_key(4'h2, 10);
        press_key(4'h3, 10);
        press_key(4'hA, 10);
        chk("seq_123A", reg_16_o, 16'h123A);
        press_key(4'hB, 10);
        chk("seq_23AB", reg_16_o, 16'h23AB);
        press_key(4'hE, 10);
        press_key(4'hF, 10);
        chk("seq_ABEF", reg_16_o, 16'hABEF);

        // Bounce on key 7, aligned to the moment row 2 becomes active.
        wait_row(4'b1101);
        wait_row(4'b1011);
        pressed[key_pos(4'h7)] = 1'b1;
        repeat (2 * SD) @(negedge clk_i);
        pressed = 16'h0;
        repeat (SD) @(negedge clk_i);
        pressed[key_pos(4'h7)] = 1'b1;
        repeat (SD) @(negedge clk_i);
        pressed = 16'h0;
        repeat (8 * SD) @(negedge clk_i);
        chk("bounce_reg", reg_16_o, exp_reg);

        pressed[key_pos(4'h1)] = 1'b1;
        pressed[key_pos(4'h2)] = 1'b1;
        last_row = row_o;
        changes  = 0;
        for (int i = 0; i < 20 * SD; i++) begin
            @(negedge clk_i);
            if (row_o != last_row) changes++;
            last_row = row_o;
        end
        pressed = 16'h0;
        chk("multi_rotates", 16'(changes), 16'd20);
        repeat (4 * SD) @(negedge clk_i);
        chk("multi_reg", reg_16_o, exp_reg);

        press_key(4'h1, 10);
        press_key(4'h2, 10);
        press_key(4'h3, 10);
        press_key(4'h4, 10);
        chk("seq_1234", reg_16_o, 16'h1234);

        // Key 5 seen from the row-1 edge: detect at +4, accept edge at +12.
        wait_row(4'b1110);
        pressed[key_pos(4'h5)] = 1'b1;
        wait_row(4'b1101);
        exp_reg = 16'h0;
        expect_key(4'h5, 16'h0000);
        repeat (11) @(posedge clk_i);
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("clr_key", {12'd0, key_o}, 16'h0005);
        chk("clr_reg", reg_16_o, 16'h0000);
        @(negedge clk_i);
        pressed = 16'h0;
        repeat (8 * SD) @(negedge clk_i);

        wait_row(4'b1110);
        pressed[key_pos(4'h5)] = 1'b1;
        wait_row(4'b1101);
        repeat (6) @(negedge clk_i);
        rst_n_i = 1'b0;
        pressed = 16'h0;
        #1;
        chk("mid_rst_row", {12'd0, row_o}, 16'h000E);
        chk("mid_rst_valid", {15'd0, key_valid_o}, 16'h0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        chk("post_rst_row", {12'd0, row_o}, 16'h000E);
        repeat (20 * SD) @(negedge clk_i);

        chk("sb_empty", 16'(sb_q.size()), 16'd0);
        chk("strobe_total", 16'(n_strobe), 16'(n_pushed));
        chk("final_reg", reg_16_o, exp_reg);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces presses, and assembles a 4-digit hexadecimal value for the processor system. It is the input-side counterpart of the 4-digit 7-segment display path. The display path shows a 16-bit register. This block builds a 16-bit register from key presses and presents it to an input port of the SoC, together with a per-key strobe.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles per scan tick (1 ms at 50 MHz); must be >= 2.
- DEBOUNCE_CNT, 8: number of consecutive identical tick samples required to accept a press or a release; must be >= 1.

Ports:
- clk_i  in  1  system clock (CLOCK_50 domain).
- rst_n_i  in  1  reset; one clock; asynchronous assert, active-low.
- col_i  in  4  keypad columns; active-low with external pull-ups; asynchronous to clk_i.
- row_o  out  4  keypad row drive; active-low, one-hot-low.
- clr_i  in  1  synchronous clear of reg_16_o; single-cycle pulse from the SoC.
- reg_16_o  out  16  entered value, most recent digit in [3:0].
- key_o  out  4  hex code of the last accepted key.
- key_valid_o  out  1  one-cycle strobe per accepted key.

## Operation
- col_i passes through a 2-flop synchronizer. Only the synchronized value (colS) is used.
- A divider counts 0..SCAN_DIV-1. A one-cycle tick fires when the count equals SCAN_DIV-1.
- Key map, written as row r, columns 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- A single valid press is colS with exactly one bit low. The pressed column is the index of that low bit.
- FSM states: SCAN, DEB_PRESS, HELD, DEB_REL.
- SCAN:
  - On each tick, sample colS for the current row.
  - If exactly one bit is low: latch the pattern, clear the debounce counter to 1, and go to DEB_PRESS. The row is held.
  - Otherwise (no bit low, or two or more bits low): advance the row 0→1→2→3→0 and stay in SCAN.
- DEB_PRESS:
  - On each tick, if colS equals the latched pattern, increment the counter.
  - When the counter reaches DEBOUNCE_CNT: accept the key and go to HELD.
  - If colS differs from the latched pattern: abandon the press, advance the row, and return to SCAN.
- With DEBOUNCE_CNT=1, a key is accepted in the same tick that detects it in SCAN.
- Accept actions:
  - key_o <= mapped code.
  - key_valid_o = 1 for one clock.
  - reg_16_o <= {reg_16_o[11:0], code}. The oldest digit is discarded.
- HELD:
  - Hold the row. No auto-repeat.
  - On a tick where colS = 4'hF, clear the counter to 1 and go to DEB_REL.
- DEB_REL:
  - On each tick where colS = 4'hF, increment the counter.
  - When the counter reaches DEBOUNCE_CNT: advance the row and go to SCAN.
  - Any low bit on a tick returns the FSM to HELD. This never produces a new accept.
- clr_i sets reg_16_o to 0 on the next edge. If clr_i and an accept occur in the same cycle, the clear wins: reg_16_o = 0. key_o and key_valid_o still update.
- Reset values:
  - row_o = 4'b1110
  - reg_16_o = 0, key_o = 0, key_valid_o = 0
  - state SCAN, divider 0, counter 0, synchronizer flops 4'hF.
- Asserting reset mid-operation, in any state, returns the block to the reset values immediately. There is no accept pending after reset is released.

## Timing
- col_i to colS latency: 2 clocks.
- Row settling: row_o changes on the clock after a tick. The next sample is taken SCAN_DIV cycles later.
- Accept timing: key_valid_o is asserted on the clock edge after the DEBOUNCE_CNT-th matching tick. reg_16_o and key_o update on that same edge.
- Minimum press-to-strobe time: (DEBOUNCE_CNT-1)·SCAN_DIV cycles plus synchronizer and phase delay. The worst case adds 4·SCAN_DIV cycles while the scan reaches the pressed row.
- key_valid_o is never asserted on two consecutive clocks. A new accept requires passing through DEB_REL and SCAN.
- All outputs are registered.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_CNT=3 for all scenarios.
- Reset: hold rst_n_i low mid-count → row_o=1110, reg_16_o=0000, key_o=0, key_valid_o=0. Release → the scan rotates 1110, 1101, 1011, 0111, 1110 every 4 clocks.
- Single press: hold row1/col2 low (key 6) for 40 ticks → exactly one key_valid_o pulse, key_o=6, reg_16_o=0x0006. No repeat while held.
- Digit sequence: press and release keys 1, 2, 3, A, each held 10 ticks → reg_16_o=0x123A. A fifth press of B → 0x23AB. Press E, then F → 0xABEF.
- Bounce: row2/col0 low for 2 ticks, high for 1 tick, low for 1 tick, then released → no strobe, and reg_16_o is unchanged.
- Multi-key: row0/col0 and row0/col1 low together for 20 ticks → no strobe, and the scan keeps rotating.
- Clear and reset: clr_i asserted on the same cycle as the accept of key 5, starting from reg_16_o=0x1234 → reg_16_o=0x0000, key_o=5, one strobe. Assert reset during DEB_PRESS → no strobe after release, and row_o=1110.
